// File: rtl/jsm_pkg.sv
// Shared types for the JTAG scan master: TAP state encoding, master phases, TMS prefixes.
// Pure declarations, no latency; no flow control of its own.
package jsm_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_t;

  typedef enum logic [2:0] {
    RESET_SEQ, IDLE, PREFIX, SHIFT, SUFFIX, RUNTEST, DONE
  } phase_t;

  localparam int         TLR_CLOCKS = 5;
  // TMS prefixes from Run-Test/Idle to Shift, LSB is the first TCK
  localparam logic [2:0] DR_PREFIX  = 3'b001;
  localparam logic [3:0] IR_PREFIX  = 4'b0011;

  function automatic tap_state_t tap_next(tap_state_t s, logic tms);
    tap_state_t n;
    n = s;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jsm_if.sv
// Host-side scan request/response bundle; idle_cnt exists only with JSM_RUNTEST_EN.
// Wires only, no latency; req is taken when req && ready.
interface jsm_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
);
  logic              req;
  logic              is_ir;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] tx_data;
  logic              ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
`ifdef JSM_RUNTEST_EN
  logic [7:0]        idle_cnt;

  modport master (output req, is_ir, len, tx_data, idle_cnt, input ready, rx_valid, rx_data);
  modport slave  (input req, is_ir, len, tx_data, idle_cnt, output ready, rx_valid, rx_data);
`else
  modport master (output req, is_ir, len, tx_data, input ready, rx_valid, rx_data);
  modport slave  (input req, is_ir, len, tx_data, output ready, rx_valid, rx_data);
`endif
endinterface

// File: rtl/jsm_tck_gen.sv
// TCK divider: toggles tck every CLK_DIV iclk cycles while en, parks tck low otherwise.
// Strobes are combinational and mark the cycle whose clock edge moves tck; no backpressure.
module jsm_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic iclk,
  input  logic resetn,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan initiator: walks the TAP for one IR/DR scan, shifts LSB first, returns TDO word.
// Latency (len+5 or len+6 TCK) plus optional run-test clocks with JSM_RUNTEST_EN; req held off by ready.
module jtag_scan_master
  import jsm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 4
) (
  input  logic iclk,
  input  logic resetn,
  jsm_if.slave bus,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo
);
  phase_t            phase;
  tap_state_t        tap_q;
  logic [2:0]        step;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              ir_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
`ifdef JSM_RUNTEST_EN
  logic [7:0]        rt_q;
`endif

  logic              tck_en;
  logic              fall_stb;
  logic              rise_stb;
  logic [LEN_W-1:0]  len_eff;
  logic [3:0]        pfx;
  logic [2:0]        pre_last;

  assign tck_en   = (phase == RESET_SEQ) || (phase == PREFIX) || (phase == SHIFT) ||
                    (phase == SUFFIX) || (phase == RUNTEST);
  assign len_eff  = (bus.len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : bus.len;
  assign pfx      = ir_q ? IR_PREFIX : {1'b0, DR_PREFIX};
  assign pre_last = ir_q ? 3'd3 : 3'd2;

  jsm_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .iclk     (iclk),
    .resetn   (resetn),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // tms/tdi always hold the value for the next rising edge; counters advance on rise
  always_ff @(posedge iclk or negedge resetn) begin
    if (!resetn) begin
      phase        <= RESET_SEQ;
      tap_q        <= TEST_LOGIC_RESET;
      step         <= '0;
      bit_cnt      <= '0;
      len_q        <= '0;
      ir_q         <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      tms          <= 1'b1;
      tdi          <= 1'b0;
      bus.ready    <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
`ifdef JSM_RUNTEST_EN
      rt_q         <= '0;
`endif
    end else begin
      bus.rx_valid <= 1'b0;
      if (rise_stb) tap_q <= tap_next(tap_q, tms);

      if (bus.ready && bus.req) begin
        ir_q    <= bus.is_ir;
        len_q   <= len_eff;
        tx_sr   <= bus.tx_data;
        rx_sr   <= '0;
        step    <= '0;
        bit_cnt <= '0;
`ifdef JSM_RUNTEST_EN
        rt_q    <= bus.idle_cnt;
`endif
        if (len_eff == '0) begin
          phase        <= DONE;
          bus.rx_valid <= 1'b1;
          bus.rx_data  <= '0;
        end else begin
          phase     <= PREFIX;
          bus.ready <= 1'b0;
          tms       <= 1'b1;
        end
      end else begin
        case (phase)
          RESET_SEQ: begin
            if (fall_stb) tms <= (step < 3'(TLR_CLOCKS));
            if (rise_stb) begin
              step <= step + 1'b1;
              if (step == 3'(TLR_CLOCKS)) begin
                phase     <= IDLE;
                step      <= '0;
                bus.ready <= 1'b1;
              end
            end
          end
          PREFIX: begin
            if (fall_stb) tms <= pfx[step[1:0]];
            if (rise_stb) begin
              step <= step + 1'b1;
              if (step == pre_last) phase <= SHIFT;
            end
          end
          SHIFT: begin
            if (fall_stb) begin
              tms <= (bit_cnt == len_q - 1'b1);
              tdi <= tx_sr[0];
            end
            if (rise_stb) begin
              rx_sr   <= rx_sr | (DATA_W'(tdo) << bit_cnt);
              tx_sr   <= tx_sr >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == len_q - 1'b1) begin
                phase <= SUFFIX;
                step  <= '0;
              end
            end
          end
          SUFFIX: begin
            if (fall_stb) tms <= (step == 3'd0);
            if (rise_stb) begin
              step <= step + 1'b1;
              if (step == 3'd1) begin
`ifdef JSM_RUNTEST_EN
                if (rt_q != 8'd0) begin
                  phase <= RUNTEST;
                end else begin
                  phase        <= DONE;
                  bus.ready    <= 1'b1;
                  bus.rx_valid <= 1'b1;
                  bus.rx_data  <= rx_sr;
                end
`else
                phase        <= DONE;
                bus.ready    <= 1'b1;
                bus.rx_valid <= 1'b1;
                bus.rx_data  <= rx_sr;
`endif
              end
            end
          end
          RUNTEST: begin
`ifdef JSM_RUNTEST_EN
            if (fall_stb) tms <= 1'b0;
            if (rise_stb) begin
              rt_q <= rt_q - 1'b1;
              if (rt_q == 8'd1) begin
                phase        <= DONE;
                bus.ready    <= 1'b1;
                bus.rx_valid <= 1'b1;
                bus.rx_data  <= rx_sr;
              end
            end
`else
            phase <= IDLE;
`endif
          end
          DONE:    phase <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Random and directed scans against a target TAP model; scoreboard of arithmetic expectations.
module tb_jtag_scan_master;
  import jsm_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  logic iclk   = 1'b0;
  logic resetn = 1'b0;
  logic tck, tms, tdi;
  logic tdo    = 1'b0;

  jsm_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  jtag_scan_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .iclk   (iclk),
    .resetn (resetn),
    .bus    (bus),
    .tck    (tck),
    .tms    (tms),
    .tdi    (tdi),
    .tdo    (tdo)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- target device: TAP, 32-bit BSR loopback, 4-bit IR
  tap_state_t  tgt = PAUSE_IR;
  logic [31:0] dr_sr = '0, dr_upd = '0, bsr_cap = '0;
  logic [3:0]  ir_sr = '0, ir_upd = '0;
  bit          tms_q[$];
  bit          tdi_q[$];

  function automatic tap_state_t tgt_next(tap_state_t s, logic m);
    case (s)
      TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return m ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        return m ? SELECT_IR : CAPTURE_DR;
      SELECT_IR:        return m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR:  return m ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR:  return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:         return m ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:         return m ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:         return m ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:         return m ? EXIT2_IR : PAUSE_IR;
      EXIT2_DR:         return m ? UPDATE_DR : SHIFT_DR;
      EXIT2_IR:         return m ? UPDATE_IR : SHIFT_IR;
      default:          return m ? SELECT_DR : RUN_TEST_IDLE;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_q.push_back(tms);
    case (tgt)
      CAPTURE_DR: dr_sr = bsr_cap;
      CAPTURE_IR: ir_sr = 4'b0001;
      SHIFT_DR: begin tdi_q.push_back(tdi); dr_sr = {tdi, dr_sr[31:1]}; end
      SHIFT_IR: begin tdi_q.push_back(tdi); ir_sr = {tdi, ir_sr[3:1]}; end
      default: ;
    endcase
    tgt = tgt_next(tgt, tms);
  end

  always @(negedge tck) begin
    case (tgt)
      SHIFT_DR:  tdo = dr_sr[0];
      SHIFT_IR:  tdo = ir_sr[0];
      UPDATE_DR: dr_upd = dr_sr;
      UPDATE_IR: ir_upd = ir_sr;
      default: ;
    endcase
  end

  // ---------------- scoreboard
  typedef struct {
    logic [63:0] rx;
    int          ntck;
    logic [63:0] tms_v;
    logic [63:0] tdi_v;
    int          ntdi;
    bit          ir;
    logic [31:0] upd;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t make_exp(bit ir, int n, logic [31:0] tx, logic [31:0] cap);
    exp_t        e;
    int          nc, k;
    logic [63:0] mask, t;
    nc   = (n > DATA_W) ? DATA_W : n;
    mask = (64'd1 << nc) - 64'd1;
    e.ir = ir;
    e.rx = ir ? ({28'b0, tx, 4'b0001} & mask) : ({tx, cap} & mask);
    e.tdi_v = {32'b0, tx} & mask;
    e.ntdi  = nc;
    t = ir ? (64'({tx, 4'b0001}) >> nc) : ({tx, cap} >> nc);
    e.upd = ir ? {28'b0, t[3:0]} : t[31:0];
    e.tms_v = '0;
    k = 0;
    if (nc > 0) begin
      e.tms_v[k++] = 1'b1;
      if (ir) e.tms_v[k++] = 1'b1;
      e.tms_v[k++] = 1'b0;
      e.tms_v[k++] = 1'b0;
      for (int i = 0; i < nc; i++) e.tms_v[k++] = (i == nc - 1);
      e.tms_v[k++] = 1'b1;
      e.tms_v[k++] = 1'b0;
    end
    e.ntck = k;
    return e;
  endfunction

  function automatic logic [63:0] pack(bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) if (i < 64) v[i] = q[i];
    return v;
  endfunction

  int cyc = 0, acc_cyc = 0, rv_cnt = 0;
  bit chk_rdy_low = 0, prev_rv = 0;

  always @(posedge iclk) cyc++;

  always @(negedge iclk) begin
    if (resetn) begin
      if (chk_rdy_low) begin
        check("ready_low_after_accept", bus.ready, 0);
        chk_rdy_low = 0;
      end
      if (prev_rv) check("rx_valid_one_cycle", bus.rx_valid, 0);
      prev_rv = bus.rx_valid;
      if (bus.rx_valid) begin
        exp_t e;
        rv_cnt++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rx_valid actual=1 required=0");
        end else begin
          e = sb.pop_front();
          check("rx_data", bus.rx_data, e.rx);
          check("ready_at_done", bus.ready, 1);
          check("tck_count", tms_q.size(), e.ntck);
          check("tms_seq", pack(tms_q), e.tms_v);
          check("tdi_count", tdi_q.size(), e.ntdi);
          check("tdi_seq", pack(tdi_q), e.tdi_v);
          if (e.ntck > 0) check(e.ir ? "ir_update" : "dr_update",
                                e.ir ? {60'b0, ir_upd} : {32'b0, dr_upd}, e.upd);
          else            check("len0_latency", cyc - acc_cyc, 1);
        end
      end
      if (bus.req && bus.ready) begin
        tms_q.delete();
        tdi_q.delete();
        acc_cyc     = cyc;
        chk_rdy_low = (bus.len != '0);
      end
    end
  end

  // ---------------- stimulus
  task automatic wait_ready(string nm);
    for (int t = 0; t < 3000; t++) begin
      if (bus.ready === 1'b1) return;
      @(posedge iclk); #1;
    end
    checks++; errors++;
    $display("FAIL %s_timeout actual=0 required=1", nm);
  endtask

  task automatic drive(bit ir, int n, logic [31:0] tx);
    bus.req     = 1'b1;
    bus.is_ir   = ir;
    bus.len     = LEN_W'(n);
    bus.tx_data = tx;
  endtask

  task automatic issue(bit ir, int n, logic [31:0] tx, logic [31:0] cap, bit expect_done);
    if (expect_done) sb.push_back(make_exp(ir, n, tx, cap));
    bsr_cap = cap;
    @(posedge iclk); #1;
    drive(ir, n, tx);
    wait_ready("accept");
    @(posedge iclk); #1;
    bus.req     = 1'b0;
    bus.tx_data = $urandom;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 3000; t++) begin
      @(posedge iclk);
      if (sb.size() == 0) begin
        @(posedge iclk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL done_timeout actual=%0d required=0", sb.size());
    sb.delete();
  endtask

  task automatic reset_release_check(string nm);
    @(negedge iclk);
    tms_q.delete();
    resetn = 1'b1;
    wait_ready(nm);
    check({nm, "_tck_count"}, tms_q.size(), 6);
    check({nm, "_tms_seq"}, pack(tms_q), 64'h1F);
    check({nm, "_mirror"}, 64'(dut.tap_q), 64'(RUN_TEST_IDLE));
    check({nm, "_target"}, 64'(tgt), 64'(RUN_TEST_IDLE));
  endtask

  initial begin
    int rv0;
    logic [31:0] cap;
    bus.req = 1'b0; bus.is_ir = 1'b0; bus.len = '0; bus.tx_data = '0;
`ifdef JSM_RUNTEST_EN
    bus.idle_cnt = 8'd0;
`endif
    repeat (3) @(posedge iclk);
    #1;
    check("reset_outputs", {tck, tms, tdi, bus.ready, bus.rx_valid}, 5'b01000);
    check("reset_rx_data", bus.rx_data, 0);
    reset_release_check("reset_seq");

    issue(0, 8, 32'h0000_00A5, 32'h0000_003C, 1); wait_done();
    issue(1, 4, 32'h2, $urandom, 1);              wait_done();
    issue(0, 0, $urandom, $urandom, 1);           wait_done();
    issue(0, 40, $urandom, $urandom, 1);          wait_done();

    // back-to-back: req stays high across two scans
    cap = $urandom;
    bsr_cap = cap;
    begin
      logic [31:0] ta, tb2;
      ta = $urandom; tb2 = $urandom;
      sb.push_back(make_exp(0, 12, ta, cap));
      sb.push_back(make_exp(1, 7, tb2, cap));
      @(posedge iclk); #1;
      drive(0, 12, ta);
      wait_ready("b2b_first");
      @(posedge iclk); #1;
      drive(1, 7, tb2);
      wait_ready("b2b_second");
      check("b2b_accept_on_ready_rise", bus.rx_valid, 1);
      @(posedge iclk); #1;
      bus.req = 1'b0;
      wait_done();
    end

    for (int i = 0; i < 14; i++) begin
      issue($urandom_range(0, 1), $urandom_range(0, 40), $urandom, $urandom, 1);
      wait_done();
    end

    // reset in the middle of a 32-bit DR shift
    rv0 = rv_cnt;
    issue(0, 32, $urandom, $urandom, 0);
    for (int t = 0; t < 3000 && tdi_q.size() < 5; t++) @(negedge iclk);
    check("midreset_reached_bit5", tdi_q.size(), 5);
    resetn = 1'b0;
    #1;
    check("midreset_outputs", {tck, tms, bus.ready, bus.rx_valid}, 4'b0100);
    repeat (3) @(posedge iclk);
    reset_release_check("midreset_seq");
    check("midreset_no_rx_valid", rv_cnt, rv0);

    issue(0, 16, $urandom, $urandom, 1); wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
